byte_memory: RTL and testbench
==============================

BYTE_MEMORY -- requirements
Module: byte_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of both address inputs.
REQ-002 SHALL have parameter DEPTH_WORDS, default 8192 (power of two): number of 32-bit words stored; IDX_BITS = log2(DEPTH_WORDS).
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port inst_addr  input  ADDR_WIDTH: instruction fetch byte address.
REQ-006 SHALL have port inst_stall  input  1: when high, hold inst_data/inst_valid.
REQ-007 SHALL have port inst_data  output  32: registered instruction word.
REQ-008 SHALL have port inst_valid  output  1: inst_data holds a fetched word.
REQ-009 SHALL have port dmem_req  input  1: data request strobe.
REQ-010 SHALL have port dmem_we  input  1: 1 = store, 0 = load.
REQ-011 SHALL have port dmem_size  input  2: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-012 SHALL have port dmem_signed  input  1: sign-extend sub-word loads when 1, zero-extend when 0.
REQ-013 SHALL have port dmem_addr  input  ADDR_WIDTH: data byte address.
REQ-014 SHALL have port dmem_wdata  input  32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-015 SHALL have port dmem_ready  output  1: request accepted on edge where dmem_req && dmem_ready.
REQ-016 SHALL have port dmem_rvalid  output  1: one-cycle response pulse for every accepted request.
REQ-017 SHALL have port dmem_rdata  output  32: load result, valid while dmem_rvalid.
REQ-018 SHALL have port dmem_err  output  1: accepted request was misaligned or reserved size; valid while dmem_rvalid.

Function
REQ-019 Word index SHALL be addr[IDX_BITS+1:2]; bits above are ignored (address wraps modulo 4*DEPTH_WORDS).
REQ-020 Byte order SHALL be big-endian: byte offset addr[1:0]=00 maps to word bits [31:24], 11 to [7:0]; halfword offset 00 maps to [31:16], 10 to [15:0].
REQ-021 Data FSM SHALL have two states: IDLE (dmem_ready=1, dmem_rvalid=0) and RESP (dmem_ready=0, dmem_rvalid=1).
REQ-022 IDLE -> RESP on edge with dmem_req=1; RESP -> IDLE unconditionally on next edge; a request presented in RESP is not accepted and must be held.
REQ-023 Latency SHALL be exactly one cycle: response appears in the cycle after acceptance; maximum throughput one request per two cycles.
REQ-024 Misaligned SHALL mean size 01 with addr[0]=1, size 10 with addr[1:0]!=00, or size 11.
REQ-025 Aligned store SHALL update only the addressed byte lanes at the acceptance edge; other lanes unchanged; response rdata=0, err=0.
REQ-026 Aligned load SHALL capture at the acceptance edge the selected byte/half/word, right-aligned and extended per dmem_signed (word loads unaffected by dmem_signed); err=0.
REQ-027 Misaligned request SHALL write nothing and respond with rdata=0, err=1.
REQ-028 dmem_rdata and dmem_err SHALL be 0 whenever dmem_rvalid=0.
REQ-029 Instruction port SHALL register mem[inst_addr index] into inst_data on every edge with inst_stall=0; with inst_stall=1, inst_data and inst_valid hold; inst_addr[1:0] is ignored.
REQ-030 On an edge where a store and an instruction fetch hit the same word, inst_data SHALL receive the pre-store contents (read-old).
REQ-031 inst_valid SHALL become 1 on the first non-stalled edge after reset is deasserted and remain 1 until reset.

Reset
REQ-032 While reset=1 at an edge: FSM -> IDLE, dmem_rvalid=0, dmem_rdata=0, dmem_err=0, inst_data=0, inst_valid=0; dmem_ready reads 1 after that edge.
REQ-033 Reset SHALL override everything: a request presented on a reset edge is not accepted and performs no write; a response in flight (RESP) is dropped.
REQ-034 Memory array contents SHALL NOT be cleared by reset.

Verification
REQ-035 Store word 0xDEADBEEF at 0x10, then load word 0x10 -> rvalid one cycle after acceptance, rdata=0xDEADBEEF, err=0.
REQ-036 Store byte 0x7F at 0x11 over that word, load word -> 0xDE7FBEEF; signed byte load at 0x12 -> 0xFFFFFFBE; unsigned -> 0x000000BE; signed half at 0x12 -> 0xFFFFBEEF.
REQ-037 Load word at 0x13, store half at 0x11, size 11 at 0x10 -> each err=1, rdata=0; subsequent load at 0x10 still 0xDE7FBEEF.
REQ-038 Hold dmem_req=1 continuously for 4 requests -> ready alternates 1,0; exactly 4 rvalid pulses, each one cycle after its acceptance.
REQ-039 Fetch 0x10 on the same edge as store 0x11223344 to 0x10 -> inst_data=0xDE7FBEEF; next fetch -> 0x11223344; stall=1 holds inst_data.
REQ-040 Assert reset in RESP cycle and with a pending store -> rvalid drops, no write occurs, inst_valid=0, memory retains prior contents.

Source files
------------

// File: rtl/byte_memory.sv
// byte_memory: single-clock word memory with a registered instruction fetch port
// and a byte-addressable, big-endian data port answering each accepted request
// with a one-cycle response pulse on the following cycle.

module byte_memory #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 8192
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_stall,
    output logic [31:0]           inst_data,
    output logic                  inst_valid,
    input  logic                  dmem_req,
    input  logic                  dmem_we,
    input  logic [1:0]            dmem_size,
    input  logic                  dmem_signed,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [31:0]           dmem_wdata,
    output logic                  dmem_ready,
    output logic                  dmem_rvalid,
    output logic [31:0]           dmem_rdata,
    output logic                  dmem_err
);

    localparam int IDX_BITS = $clog2(DEPTH_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } dataState_t;

    // Storage array; deliberately never cleared so contents survive reset.
    logic [31:0] r_mem [DEPTH_WORDS];

    dataState_t r_state;
    dataState_t w_nextState;

    logic [31:0]         r_instData;
    logic                r_instValid;
    logic [31:0]         r_rdata;
    logic                r_err;

    logic [IDX_BITS-1:0] w_dataIdx;
    logic [IDX_BITS-1:0] w_instIdx;
    logic [1:0]          w_offset;
    logic                w_accept;
    logic                w_misaligned;
    logic [31:0]         w_rdWord;
    logic [7:0]          w_loadByte;
    logic [15:0]         w_loadHalf;
    logic [31:0]         w_loadData;
    logic [31:0]         w_respData;
    logic [3:0]          w_byteEn;
    logic [31:0]         w_storeLanes;
    logic                w_unused;

    // Upper address bits and the instruction byte offset are intentionally ignored.
    assign w_unused = ^{inst_addr, dmem_addr};

    assign w_dataIdx = dmem_addr[IDX_BITS+1:2];
    assign w_instIdx = inst_addr[IDX_BITS+1:2];
    assign w_offset  = dmem_addr[1:0];
    assign w_rdWord  = r_mem[w_dataIdx];
    assign w_accept  = dmem_req && (r_state == IDLE) && !reset;

    // Misalignment: odd halfword, non-word-aligned word, or the reserved size.
    always_comb begin
        w_misaligned = 1'b0;
        case (dmem_size)
            2'b01:   w_misaligned = w_offset[0];
            2'b10:   w_misaligned = (w_offset != 2'b00);
            2'b11:   w_misaligned = 1'b1;
            default: w_misaligned = 1'b0;
        endcase
    end

    // Big-endian lane selection and sign/zero extension of load data.
    always_comb begin
        w_loadByte = w_rdWord[31:24];
        case (w_offset)
            2'b00:   w_loadByte = w_rdWord[31:24];
            2'b01:   w_loadByte = w_rdWord[23:16];
            2'b10:   w_loadByte = w_rdWord[15:8];
            default: w_loadByte = w_rdWord[7:0];
        endcase
        w_loadHalf = w_offset[1] ? w_rdWord[15:0] : w_rdWord[31:16];
        w_loadData = w_rdWord;
        case (dmem_size)
            2'b00:   w_loadData = dmem_signed ? {{24{w_loadByte[7]}}, w_loadByte}
                                              : {24'h000000, w_loadByte};
            2'b01:   w_loadData = dmem_signed ? {{16{w_loadHalf[15]}}, w_loadHalf}
                                              : {16'h0000, w_loadHalf};
            default: w_loadData = w_rdWord;
        endcase
        w_respData = (dmem_we || w_misaligned) ? 32'h0 : w_loadData;
    end

    // Store byte enables and replicated write lanes; misaligned stores enable nothing.
    always_comb begin
        w_byteEn     = 4'b0000;
        w_storeLanes = 32'h0;
        if (dmem_we && !w_misaligned) begin
            case (dmem_size)
                2'b00: begin
                    w_byteEn     = 4'b1000 >> w_offset;
                    w_storeLanes = {4{dmem_wdata[7:0]}};
                end
                2'b01: begin
                    w_byteEn     = w_offset[1] ? 4'b0011 : 4'b1100;
                    w_storeLanes = {2{dmem_wdata[15:0]}};
                end
                2'b10: begin
                    w_byteEn     = 4'b1111;
                    w_storeLanes = dmem_wdata;
                end
                default: begin
                    w_byteEn     = 4'b0000;
                    w_storeLanes = 32'h0;
                end
            endcase
        end
    end

    // Byte-lane memory write on the acceptance edge.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b]) begin
                    r_mem[w_dataIdx][b*8 +: 8] <= w_storeLanes[b*8 +: 8];
                end
            end
        end
    end

    // Data FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Data FSM next state and handshake outputs.
    always_comb begin
        w_nextState = r_state;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        case (r_state)
            IDLE: begin
                dmem_ready = 1'b1;
                if (dmem_req) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                dmem_rvalid = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Response payload captured at acceptance and zero in every other cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= w_respData;
            r_err   <= w_misaligned;
        end else begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end
    end

    // Instruction fetch register; reads the pre-store word on a same-edge store.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instData  <= 32'h0;
            r_instValid <= 1'b0;
        end else if (!inst_stall) begin
            r_instData  <= r_mem[w_instIdx];
            r_instValid <= 1'b1;
        end
    end

    assign inst_data  = r_instData;
    assign inst_valid = r_instValid;
    assign dmem_rdata = r_rdata;
    assign dmem_err   = r_err;

endmodule

// File: tb/tb_byte_memory.sv
// tb_byte_memory: scoreboard bench for byte_memory. Expected responses are queued
// when a request is presented to an idle port and checked when rvalid pulses.

module tb_byte_memory;

    logic        clk;
    logic        reset;
    logic [31:0] inst_addr;
    logic        inst_stall;
    logic [31:0] inst_data;
    logic        inst_valid;
    logic        dmem_req;
    logic        dmem_we;
    logic [1:0]  dmem_size;
    logic        dmem_signed;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        int          respCycle;
    } expItem_t;

    expItem_t expQueue[$];
    int checks     = 0;
    int failures   = 0;
    int cycleCount = 0;
    int rvalidSeen = 0;

    byte_memory #(.ADDR_WIDTH(32), .DEPTH_WORDS(8192)) dut (
        .clk(clk),
        .reset(reset),
        .inst_addr(inst_addr),
        .inst_stall(inst_stall),
        .inst_data(inst_data),
        .inst_valid(inst_valid),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_size(dmem_size),
        .dmem_signed(dmem_signed),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .dmem_err(dmem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to verify one-cycle response latency.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Present one request at a falling edge, queue its expected response once the
    // port is idle, and leave the bench on the falling edge of the response cycle.
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input logic expErr, input logic hold);
        expItem_t item;
        int waitCount;
        dmem_req    = 1'b1;
        dmem_we     = we;
        dmem_size   = size;
        dmem_signed = sgn;
        dmem_addr   = addr;
        dmem_wdata  = wdata;
        waitCount   = 0;
        while (!dmem_ready && waitCount < 8) begin
            @(negedge clk);
            waitCount++;
        end
        if (!dmem_ready) begin
            checkOutput({tag, "_accept_timeout"}, 32'd1, 32'd0);
            dmem_req = 1'b0;
            return;
        end
        item.tag       = tag;
        item.data      = expData;
        item.err       = expErr;
        item.respCycle = cycleCount + 1;
        expQueue.push_back(item);
        @(negedge clk);
        checkOutput({tag, "_ready_low"}, {31'b0, dmem_ready}, 32'd0);
        if (!hold) dmem_req = 1'b0;
    endtask

    // Response monitor: pops the scoreboard on every rvalid pulse.
    initial begin
        expItem_t item;
        forever begin
            @(negedge clk);
            if (dmem_rvalid === 1'b1) begin
                rvalidSeen++;
                if (expQueue.size() == 0) begin
                    checkOutput("spurious_rvalid", 32'd1, 32'd0);
                end else begin
                    item = expQueue.pop_front();
                    checkOutput({item.tag, "_rdata"}, dmem_rdata, item.data);
                    checkOutput({item.tag, "_err"}, {31'b0, dmem_err}, {31'b0, item.err});
                    checkOutput({item.tag, "_latency"}, cycleCount, item.respCycle);
                end
            end else begin
                checkOutput("idle_rdata_zero", dmem_rdata, 32'h0);
                checkOutput("idle_err_zero", {31'b0, dmem_err}, 32'h0);
            end
        end
    end

    initial begin
        int pulsesBefore;
        reset       = 1'b1;
        inst_addr   = 32'h10;
        inst_stall  = 1'b1;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_size   = 2'b10;
        dmem_signed = 1'b0;
        dmem_addr   = 32'h0;
        dmem_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", {31'b0, dmem_ready}, 32'd1);
        checkOutput("rst_rvalid", {31'b0, dmem_rvalid}, 32'd0);
        checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("rst_inst_data", inst_data, 32'h0);

        reset = 1'b0;
        @(negedge clk);
        checkOutput("stalled_inst_valid", {31'b0, inst_valid}, 32'd0);
        inst_stall = 1'b0;
        @(negedge clk);
        checkOutput("first_fetch_valid", {31'b0, inst_valid}, 32'd1);

        // Word store and load back.
        applyStimulus("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        applyStimulus("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        // Sub-word store and big-endian loads with both extensions.
        applyStimulus("st_b11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000007F, 32'h0, 1'b0, 1'b0);
        applyStimulus("ld_w10b", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hDE7FBEEF, 1'b0, 1'b0);
        applyStimulus("ld_sb12", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'hFFFFFFBE, 1'b0, 1'b0);
        applyStimulus("ld_ub12", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h000000BE, 1'b0, 1'b0);
        applyStimulus("ld_sh12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0, 1'b0);
        applyStimulus("ld_uh10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000DE7F, 1'b0, 1'b0);
        applyStimulus("ld_sb11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000007F, 1'b0, 1'b0);
        applyStimulus("ld_ub13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h000000EF, 1'b0, 1'b0);
        // Misaligned and reserved-size requests.
        applyStimulus("ld_w13_mis", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0);
        applyStimulus("st_h11_mis", 1'b1, 2'b01, 1'b0, 32'h11, 32'hAAAA5555, 32'h0, 1'b1, 1'b0);
        applyStimulus("sz11_mis", 1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, 32'h0, 1'b1, 1'b0);
        applyStimulus("ld_w10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDE7FBEEF, 1'b0, 1'b0);
        applyStimulus("ld_wrap", 1'b0, 2'b10, 1'b0, 32'h8010, 32'h0, 32'hDE7FBEEF, 1'b0, 1'b0);
        // Halfword lanes of a neighbouring word.
        applyStimulus("st_w14", 1'b1, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus("st_h16", 1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF1234, 32'h0, 1'b0, 1'b0);
        applyStimulus("ld_w14a", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h00001234, 1'b0, 1'b0);
        applyStimulus("st_h14", 1'b1, 2'b01, 1'b0, 32'h14, 32'h0000ABCD, 32'h0, 1'b0, 1'b0);
        applyStimulus("ld_w14b", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hABCD1234, 1'b0, 1'b0);

        // Four back-to-back requests with dmem_req held high.
        @(negedge clk);
        pulsesBefore = rvalidSeen;
        applyStimulus("hold0", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDE7FBEEF, 1'b0, 1'b1);
        applyStimulus("hold1", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hABCD1234, 1'b0, 1'b1);
        applyStimulus("hold2", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 32'h00001234, 1'b0, 1'b1);
        applyStimulus("hold3", 1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 32'hFFFFFFAB, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("hold_pulse_count", rvalidSeen - pulsesBefore, 32'd4);

        // Same-edge store and fetch returns the old word, then the new one.
        inst_addr = 32'h10;
        applyStimulus("st_w10_fetch", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 1'b0);
        checkOutput("fetch_read_old", inst_data, 32'hDE7FBEEF);
        @(negedge clk);
        checkOutput("fetch_new", inst_data, 32'h11223344);
        inst_stall = 1'b1;
        inst_addr  = 32'h14;
        @(negedge clk);
        @(negedge clk);
        checkOutput("fetch_stall_hold", inst_data, 32'h11223344);
        checkOutput("fetch_stall_valid", {31'b0, inst_valid}, 32'd1);

        // Reset during a response and with a pending store.
        applyStimulus("ld_pre_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 1'b1);
        reset      = 1'b1;
        dmem_we    = 1'b1;
        dmem_size  = 2'b10;
        dmem_addr  = 32'h10;
        dmem_wdata = 32'hCAFEBABE;
        @(negedge clk);
        checkOutput("rst_drop_rvalid", {31'b0, dmem_rvalid}, 32'd0);
        checkOutput("rst_inst_valid2", {31'b0, inst_valid}, 32'd0);
        checkOutput("rst_inst_data2", inst_data, 32'h0);
        @(negedge clk);
        checkOutput("rst_no_accept", {31'b0, dmem_rvalid}, 32'd0);
        dmem_req   = 1'b0;
        reset      = 1'b0;
        inst_stall = 1'b0;
        inst_addr  = 32'h10;
        @(negedge clk);
        checkOutput("post_rst_fetch_valid", {31'b0, inst_valid}, 32'd1);
        checkOutput("post_rst_fetch_data", inst_data, 32'h11223344);
        applyStimulus("ld_post_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", expQueue.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
